// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86 stage sequencer: steps one instruction through F/D/E/M/W/PC and
// reports the final processor status. State is visible on fsm_state for checkers.
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        mem_ack,
    input  logic        dmem_error,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        mem_req,
    output logic        wb_en,
    output logic        pc_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPDATE, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t     state, state_nxt;
    logic [2:0] stat_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       inc_instr;
    logic       is_mem;

    assign fsm_state = state;
    assign is_mem = (icode == 4'd4) || (icode == 4'd5) || (icode == 4'd8) ||
                    (icode == 4'd9) || (icode == 4'd10) || (icode == 4'd11);

    // Memory handshake: mem_req stays high for the whole MEMORY state; the first
    // cycle with mem_ack=1 completes the access and dmem_error is only meaningful then.
    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        wait_nxt  = wait_cnt;
        inc_instr = 1'b0;
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_INS;
                end else if (icode == 4'd0) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_HLT;
                    inc_instr = 1'b1;
                end else begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (is_mem) begin
                    state_nxt = S_MEMORY;
                    wait_nxt  = 8'd1;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack) begin
                    if (dmem_error) begin
                        state_nxt = S_HALT;
                        stat_nxt  = STAT_ADR;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (wait_cnt >= 8'(MEM_TIMEOUT)) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_ADR;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            S_WRITEBACK: state_nxt = S_PCUPDATE;
            S_PCUPDATE: begin
                state_nxt = S_FETCH;
                inc_instr = 1'b1;
            end
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            stat        <= STAT_AOK;
            halted      <= 1'b0;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            execute_en  <= 1'b0;
            mem_req     <= 1'b0;
            wb_en       <= 1'b0;
            pc_en       <= 1'b0;
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
            wait_cnt    <= 8'd0;
        end else begin
            state       <= state_nxt;
            stat        <= stat_nxt;
            wait_cnt    <= wait_nxt;
            halted      <= (state_nxt == S_HALT);
            fetch_en    <= (state_nxt == S_FETCH);
            decode_en   <= (state_nxt == S_DECODE);
            execute_en  <= (state_nxt == S_EXECUTE);
            mem_req     <= (state_nxt == S_MEMORY);
            wb_en       <= (state_nxt == S_WRITEBACK);
            pc_en       <= (state_nxt == S_PCUPDATE);
            if (state != S_IDLE && state != S_HALT) cycle_count <= cycle_count + 32'd1;
            if (inc_instr) instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Cycle-accurate bench for seq_stage_controller: per-cycle expected state/enables/status
// go through an expected queue, counters are checked against a running model.
module tb_seq_stage_controller;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                           S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_PCUPDATE = 3'd6, S_HALT = 3'd7;
    localparam int MEM_TIMEOUT = 15;

    logic        Clk, Reset, start, instr_valid, imem_error, mem_ack, dmem_error;
    logic [3:0]  icode;
    logic        fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, halted;
    logic [2:0]  stat, fsm_state;
    logic [31:0] cycle_count, instr_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] exp_q[$];
    logic [31:0] exp_cycles, exp_instr;

    seq_stage_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en), .mem_req(mem_req),
        .wb_en(wb_en), .pc_en(pc_en), .stat(stat), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count), .fsm_state(fsm_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [12:0] mk(input logic [2:0] st, input logic [2:0] sc);
        return {st, st == S_FETCH, st == S_DECODE, st == S_EXECUTE, st == S_MEMORY,
                st == S_WRITEBACK, st == S_PCUPDATE, sc, st == S_HALT};
    endfunction

    function automatic logic [12:0] observed();
        return {fsm_state, fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, stat, halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [2:0] st, input logic [2:0] sc);
        logic [12:0] e;
        exp_q.push_back(mk(st, sc));
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'(observed()), 32'(e));
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cycles"}, cycle_count, exp_cycles);
        check({tag, "_instrs"}, instr_count, exp_instr);
    endtask

    task automatic do_reset();
        start = 0; icode = 4'd0; instr_valid = 0; imem_error = 0; mem_ack = 0; dmem_error = 0;
        @(negedge Clk);
        Reset = 1;
        #1;
        check("reset_vec", 32'(observed()), 32'(mk(S_IDLE, 3'd1)));
        @(negedge Clk);
        Reset = 0;
        exp_cycles = 0;
        exp_instr = 0;
        check_counters("reset");
    endtask

    task automatic start_run();
        start = 1;
        expect_state("start", S_FETCH, 3'd1);
        start = 0;
    endtask

    // Called while the DUT sits in FETCH; leaves it back in FETCH.
    task automatic do_instr(input logic [3:0] code, input int lat);
        logic mem;
        mem = code inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
        icode = code;
        instr_valid = 1;
        expect_state("decode", S_DECODE, 3'd1);
        expect_state("execute", S_EXECUTE, 3'd1);
        if (mem) begin
            expect_state("mem_enter", S_MEMORY, 3'd1);
            for (int k = 1; k <= lat; k++) begin
                mem_ack = (k == lat);
                if (k < lat) expect_state("mem_wait", S_MEMORY, 3'd1);
                else expect_state("mem_done", S_WRITEBACK, 3'd1);
            end
            mem_ack = 0;
        end else begin
            expect_state("writeback", S_WRITEBACK, 3'd1);
        end
        expect_state("pcupdate", S_PCUPDATE, 3'd1);
        expect_state("refetch", S_FETCH, 3'd1);
        exp_cycles += 32'(5 + (mem ? lat : 0));
        exp_instr += 1;
    endtask

    task automatic mem_timeout(input logic ack_last);
        icode = 4'd4;
        instr_valid = 1;
        expect_state("to_decode", S_DECODE, 3'd1);
        expect_state("to_execute", S_EXECUTE, 3'd1);
        expect_state("to_mem", S_MEMORY, 3'd1);
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            mem_ack = ack_last && (k == MEM_TIMEOUT);
            if (k < MEM_TIMEOUT) expect_state("to_wait", S_MEMORY, 3'd1);
            else if (ack_last) expect_state("to_ack_wins", S_WRITEBACK, 3'd1);
            else expect_state("to_halt", S_HALT, 3'd3);
        end
        mem_ack = 0;
        exp_cycles += 32'(3 + MEM_TIMEOUT);
        if (ack_last) begin
            expect_state("to_pcupdate", S_PCUPDATE, 3'd1);
            expect_state("to_refetch", S_FETCH, 3'd1);
            exp_cycles += 2;
            exp_instr += 1;
        end
    endtask

    initial begin
        Reset = 1;
        exp_cycles = 0;
        exp_instr = 0;
        do_reset();

        // Idle without start stays idle.
        expect_state("idle_hold", S_IDLE, 3'd1);
        check_counters("idle");

        // Single OPq instruction.
        start_run();
        do_instr(4'd6, 0);
        check_counters("opq");

        // mrmovq with a three-cycle memory wait.
        do_reset();
        start_run();
        do_instr(4'd5, 3);
        check_counters("mrmovq");

        // Timeout without ack, then start pulses while halted change nothing.
        do_reset();
        start_run();
        mem_timeout(1'b0);
        check_counters("timeout");
        start = 1;
        repeat (3) expect_state("halt_start", S_HALT, 3'd3);
        start = 0;
        check_counters("halt_frozen");

        // Ack on the timeout cycle completes normally.
        do_reset();
        start_run();
        mem_timeout(1'b1);
        check_counters("ack_on_timeout");

        // Data memory fault on ack.
        do_reset();
        start_run();
        icode = 4'd8;
        instr_valid = 1;
        expect_state("derr_decode", S_DECODE, 3'd1);
        expect_state("derr_execute", S_EXECUTE, 3'd1);
        mem_ack = 1;
        dmem_error = 1;
        expect_state("derr_mem", S_MEMORY, 3'd1);
        expect_state("derr_halt", S_HALT, 3'd3);
        mem_ack = 0;
        dmem_error = 0;
        exp_cycles += 4;
        check_counters("derr");

        // Fetch-time halts: HLT instruction, invalid, address fault.
        do_reset();
        start_run();
        icode = 4'd0;
        instr_valid = 1;
        expect_state("hlt", S_HALT, 3'd2);
        expect_state("hlt_hold", S_HALT, 3'd2);
        exp_cycles += 1;
        exp_instr += 1;
        check_counters("hlt");

        do_reset();
        start_run();
        icode = 4'd6;
        instr_valid = 0;
        expect_state("ins", S_HALT, 3'd4);
        exp_cycles += 1;
        check_counters("ins");

        do_reset();
        start_run();
        icode = 4'd6;
        instr_valid = 0;
        imem_error = 1;
        expect_state("adr", S_HALT, 3'd3);
        imem_error = 0;
        exp_cycles += 1;
        check_counters("adr");

        // Reset asserted between edges while in MEMORY.
        do_reset();
        start_run();
        icode = 4'd9;
        instr_valid = 1;
        expect_state("rst_decode", S_DECODE, 3'd1);
        expect_state("rst_execute", S_EXECUTE, 3'd1);
        expect_state("rst_mem", S_MEMORY, 3'd1);
        expect_state("rst_mem2", S_MEMORY, 3'd1);
        #1;
        Reset = 1;
        #1;
        check("rst_mid_vec", 32'(observed()), 32'(mk(S_IDLE, 3'd1)));
        check("rst_mid_cycles", cycle_count, 32'd0);
        check("rst_mid_instrs", instr_count, 32'd0);
        @(negedge Clk);
        Reset = 0;
        exp_cycles = 0;
        exp_instr = 0;
        expect_state("rst_idle", S_IDLE, 3'd1);

        // Start held high during EXECUTE is ignored.
        start_run();
        icode = 4'd6;
        instr_valid = 1;
        expect_state("se_decode", S_DECODE, 3'd1);
        expect_state("se_execute", S_EXECUTE, 3'd1);
        start = 1;
        expect_state("se_writeback", S_WRITEBACK, 3'd1);
        start = 0;
        expect_state("se_pcupdate", S_PCUPDATE, 3'd1);
        expect_state("se_refetch", S_FETCH, 3'd1);
        exp_cycles += 5;
        exp_instr += 1;
        check_counters("start_in_exec");

        // Random instruction stream back to back.
        for (int i = 0; i < 10; i++) begin
            do_instr(4'($urandom_range(1, 15)), int'($urandom_range(1, 6)));
        end
        check_counters("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles MEMORY waits for mem_ack; legal range 1..255.
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge; one clock, no other clock.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin execution; sampled only in IDLE.
REQ-005 SHALL have port icode  input  4  current instruction code from fetch; sampled only at FETCH and EXECUTE exit.
REQ-006 SHALL have port instr_valid  input  1  fetch reports legal icode/ifun.
REQ-007 SHALL have port imem_error  input  1  fetch reports instruction-address fault.
REQ-008 SHALL have port mem_ack  input  1  data memory completion strobe.
REQ-009 SHALL have port dmem_error  input  1  data memory fault; qualified by mem_ack.
REQ-010 SHALL have ports fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en  output  1 each  stage enables.
REQ-011 SHALL have port stat  output  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-012 SHALL have port halted  output  1  processor stopped.
REQ-013 SHALL have ports cycle_count, instr_count  output  32 each  performance counters.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT.
REQ-015 SHALL drive each stage enable as a Moore output: high exactly in its state (fetch_en FETCH, decode_en DECODE, execute_en EXECUTE, mem_req MEMORY, wb_en WRITEBACK, pc_en PCUPDATE), low elsewhere.
REQ-016 SHALL go IDLE->FETCH on start=1; stay IDLE otherwise; start ignored outside IDLE.
REQ-017 SHALL leave FETCH after one cycle with priority: imem_error -> HALT, stat=3; else !instr_valid -> HALT, stat=4; else icode==0 -> HALT, stat=2, instr_count+1; else DECODE.
REQ-018 SHALL hold DECODE and EXECUTE one cycle each, DECODE->EXECUTE unconditionally.
REQ-019 SHALL leave EXECUTE to MEMORY when icode in {4,5,8,9,10,11}, else to WRITEBACK.
REQ-020 SHALL hold MEMORY with mem_req=1 until mem_ack=1; on ack: dmem_error=1 -> HALT, stat=3; else WRITEBACK.
REQ-021 SHALL count MEMORY wait cycles from 1 on entry; if count reaches MEM_TIMEOUT with no ack -> HALT, stat=3; ack in the same cycle as timeout wins.
REQ-022 SHALL hold WRITEBACK and PCUPDATE one cycle each; PCUPDATE increments instr_count and returns to FETCH.
REQ-023 SHALL make HALT absorbing: all enables 0, halted=1, stat frozen, counters frozen; only Reset exits.
REQ-024 SHALL increment cycle_count on every cycle the state is neither IDLE nor HALT; both counters wrap modulo 2^32.
REQ-025 SHALL keep stat=1 in all states other than HALT.
REQ-026 SHALL complete a non-memory instruction in 5 cycles (F,D,E,W,PC) and a memory one in 5+N cycles, N = MEMORY cycles (N>=1).

Reset
REQ-027 SHALL on Reset=1, asynchronously and regardless of state: state=IDLE, all enables 0, stat=1, halted=0, counters 0, wait counter 0.
REQ-028 SHALL abort any in-flight instruction on Reset mid-operation; no enable pulses after Reset assertion.
REQ-029 SHALL begin operation on the first rising Clk after Reset deassertion with start=1.

Verification
REQ-030 SHALL verify: start, icode=6 (OPq), valid -> enables pulse F,D,E,W,PC one cycle each, instr_count=1, cycle_count=5, back in FETCH.
REQ-031 SHALL verify: icode=5 (mrmovq), mem_ack after 3 MEMORY cycles, dmem_error=0 -> mem_req high exactly 3 cycles, WRITEBACK follows, instr_count=1.
REQ-032 SHALL verify: icode=4 with no ack, MEM_TIMEOUT=15 -> HALT after 15th MEMORY cycle, stat=3, halted=1; mem_ack on 15th cycle -> WRITEBACK instead.
REQ-033 SHALL verify: FETCH with icode=0 -> HALT, stat=2, instr_count+1; with instr_valid=0 -> stat=4; with imem_error=1 and instr_valid=0 -> stat=3.
REQ-034 SHALL verify: Reset asserted mid-MEMORY between clock edges -> outputs reset immediately, mem_req=0, counters 0, state IDLE.
REQ-035 SHALL verify: start pulsed during EXECUTE and during HALT -> no effect on state, counters, or stat.
